// File: rtl/sram_banked_pkg.sv
// Shared helpers for the banked SRAM slave: parameter arithmetic used by
// the top level and by the control FSM.
package sram_banked_pkg;

  // Larger of two integers, used to size the wait counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Index width that never collapses to zero bits for a count of one.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/sram_banked_encoding.vh
// State encoding and wait-counter width for the banked SRAM control FSM.
// Included inside a module body that imports sram_banked_pkg and declares
// RD_WAIT / WR_WAIT parameters.
typedef enum logic [1:0] {
  IDLE = 2'd0,
  WAIT = 2'd1,
  ACK  = 2'd2
} state_e;

// Counter holds the larger base wait plus one penalty cycle.
localparam int CNT_W = $clog2(max_int(RD_WAIT, WR_WAIT) + 2);

// File: rtl/sram_banked_fsm.sv
// Control FSM for the banked SRAM: wait-state counting, same-bank recovery
// penalty, abort handling, error tracking and the one-cycle ack pulse.
//
// Handshake: the master raises abus_sread or abus_swrite with a stable
// address and holds it until abus_sack; ack is a single-cycle pulse and the
// request must be dropped in the cycle after ack or it starts a new
// transaction. access_en marks the cycle whose closing edge commits the
// access; the memory and read-data register act only in that cycle.
module sram_banked_fsm
  import sram_banked_pkg::*;
#(
  parameter int BANK_W  = 1,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 1
) (
  input  logic              abus_clk,
  input  logic              abus_rst,
  input  logic              sread,
  input  logic              swrite,
  input  logic              sabort,
  input  logic              in_range,
  input  logic [BANK_W-1:0] bank,
  output logic              access_en,
  output logic              ack,
  output logic              err
);

  `include "sram_banked_encoding.vh"

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic              err_q;
  logic [BANK_W-1:0] last_bank;
  logic              last_valid;
  logic [CNT_W-1:0]  base_cnt;
  logic [CNT_W-1:0]  load_cnt;
  logic              req_err;

  // Wait count for a new request: base by direction, plus recovery penalty
  // when hitting the bank touched by the last completed access.
  always_comb begin
    base_cnt = sread ? CNT_W'(RD_WAIT) : CNT_W'(WR_WAIT);
    req_err  = (sread && swrite) || !in_range;
    load_cnt = base_cnt;
    if (!req_err && last_valid && (bank == last_bank)) begin
      load_cnt = base_cnt + CNT_W'(1);
    end
  end

  // Access commits at the end of the last WAIT cycle unless aborted or reset.
  assign access_en = !abus_rst && (state == WAIT) && !sabort && (cnt == '0);
  assign err       = err_q;

  // State register, wait counter, error flag, last-bank tracking and ack.
  always_ff @(posedge abus_clk) begin
    if (abus_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      err_q      <= 1'b0;
      last_bank  <= '0;
      last_valid <= 1'b0;
      ack        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 1'b0;
          if (sread || swrite) begin
            state <= WAIT;
            err_q <= req_err;
            cnt   <= load_cnt;
          end
        end
        WAIT: begin
          if (sabort) begin
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= ACK;
            ack   <= 1'b1;
            if (!err_q) begin
              last_bank  <= bank;
              last_valid <= 1'b1;
            end
          end
        end
        ACK: begin
          state <= IDLE;
          ack   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ack   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sram_banked.sv
// Multi-bank SRAM slave for the abus arbiter: address decode, interleaved
// bank arrays with byte-lane writes, and a registered read-data output that
// holds between reads and clears on error completions.
module sram_banked
  import sram_banked_pkg::*;
#(
  parameter int START_ADDR = 0,
  parameter int SIZE       = 256,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BANKS      = 2,
  parameter int RD_WAIT    = 2,
  parameter int WR_WAIT    = 1
) (
  input  logic                    abus_clk,
  input  logic                    abus_rst,
  input  logic                    abus_swrite,
  input  logic                    abus_sread,
  input  logic                    abus_sabort,
  input  logic [ADDR_WIDTH-1:0]   abus_saddress,
  input  logic [DATA_WIDTH-1:0]   abus_swdata,
  input  logic [DATA_WIDTH/8-1:0] abus_sstrb,
  output logic                    abus_sack,
  output logic                    abus_serror,
  output logic [DATA_WIDTH-1:0]   abus_srdata
);

  localparam int NB      = DATA_WIDTH / 8;
  localparam int ROWS    = SIZE / BANKS;
  localparam int BANK_W  = clog2_min1(BANKS);
  localparam int BANK_SH = $clog2(BANKS);
  localparam int ROW_W   = clog2_min1(ROWS);
  localparam logic [ADDR_WIDTH:0] LO_ADDR = (ADDR_WIDTH+1)'(START_ADDR);
  localparam logic [ADDR_WIDTH:0] HI_ADDR = (ADDR_WIDTH+1)'(START_ADDR + SIZE);

  logic [ADDR_WIDTH-1:0] idx;
  logic                  in_range;
  logic [BANK_W-1:0]     bank;
  logic [ROW_W-1:0]      row;
  logic                  access_en;
  logic                  ack;
  logic                  err;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] bank_rd [BANKS];

  // Decode: low index bits pick the bank, the rest pick the row.
  assign idx      = abus_saddress - ADDR_WIDTH'(START_ADDR);
  assign in_range = ({1'b0, abus_saddress} >= LO_ADDR) && ({1'b0, abus_saddress} < HI_ADDR);
  assign bank     = BANK_W'(idx & ADDR_WIDTH'(BANKS - 1));
  assign row      = ROW_W'(idx >> BANK_SH);

  // Error transactions never touch memory.
  assign wr_en = access_en && !err && abus_swrite;

  sram_banked_fsm #(
    .BANK_W  (BANK_W),
    .RD_WAIT (RD_WAIT),
    .WR_WAIT (WR_WAIT)
  ) u_fsm (
    .abus_clk  (abus_clk),
    .abus_rst  (abus_rst),
    .sread     (abus_sread),
    .swrite    (abus_swrite),
    .sabort    (abus_sabort),
    .in_range  (in_range),
    .bank      (bank),
    .access_en (access_en),
    .ack       (ack),
    .err       (err)
  );

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [ROWS];

    assign bank_rd[b] = mem[row];

    // Byte-lane merge: only strobed bytes of the selected row are written.
    always_ff @(posedge abus_clk) begin
      if (wr_en && (bank == BANK_W'(b))) begin
        for (int i = 0; i < NB; i++) begin
          if (abus_sstrb[i]) begin
            mem[row][8*i +: 8] <= abus_swdata[8*i +: 8];
          end
        end
      end
    end
  end

  // Read data register: loads on read commit, clears on error commit.
  always_ff @(posedge abus_clk) begin
    if (abus_rst) begin
      abus_srdata <= '0;
    end else if (access_en) begin
      if (err) begin
        abus_srdata <= '0;
      end else if (abus_sread) begin
        abus_srdata <= bank_rd[bank];
      end
    end
  end

  assign abus_sack   = ack;
  assign abus_serror = ack && err;

endmodule

// File: tb/tb_sram_banked.sv
// Directed bench for sram_banked with START_ADDR=0x100, SIZE=256, BANKS=2,
// RD_WAIT=2, WR_WAIT=1. Ack cycles are counted from cycle 0, the first
// cycle the request is high in IDLE.
module tb_sram_banked;

  logic        abus_clk;
  logic        abus_rst;
  logic        abus_swrite;
  logic        abus_sread;
  logic        abus_sabort;
  logic [15:0] abus_saddress;
  logic [31:0] abus_swdata;
  logic [3:0]  abus_sstrb;
  logic        abus_sack;
  logic        abus_serror;
  logic [31:0] abus_srdata;

  int checks   = 0;
  int failures = 0;

  sram_banked #(
    .START_ADDR (16'h100),
    .SIZE       (256),
    .ADDR_WIDTH (16),
    .DATA_WIDTH (32),
    .BANKS      (2),
    .RD_WAIT    (2),
    .WR_WAIT    (1)
  ) dut (
    .abus_clk      (abus_clk),
    .abus_rst      (abus_rst),
    .abus_swrite   (abus_swrite),
    .abus_sread    (abus_sread),
    .abus_sabort   (abus_sabort),
    .abus_saddress (abus_saddress),
    .abus_swdata   (abus_swdata),
    .abus_sstrb    (abus_sstrb),
    .abus_sack     (abus_sack),
    .abus_serror   (abus_serror),
    .abus_srdata   (abus_srdata)
  );

  // Clock and reset block
  initial abus_clk = 1'b0;
  always #5 abus_clk = ~abus_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one request from a negedge (cycle 0) and waits for ack, bounded.
  // Returns with the bench at the negedge of cycle N+3, request low.
  task automatic do_txn(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [31:0] wd, input logic [3:0] st,
                        output int cyc, output logic err, output logic [31:0] rdat);
    abus_sread    = rd;
    abus_swrite   = wr;
    abus_saddress = addr;
    abus_swdata   = wd;
    abus_sstrb    = st;
    cyc  = -1;
    err  = 1'b0;
    rdat = '0;
    for (int k = 1; k <= 20 && cyc < 0; k++) begin
      @(posedge abus_clk);
      @(negedge abus_clk);
      if (abus_sack) begin
        cyc  = k;
        err  = abus_serror;
        rdat = abus_srdata;
      end
    end
    abus_sread  = 1'b0;
    abus_swrite = 1'b0;
    @(posedge abus_clk);
    @(negedge abus_clk);
  endtask

  // Counts ack pulses over n cycles.
  task automatic count_acks(input int n, output int seen);
    seen = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge abus_clk);
      @(negedge abus_clk);
      if (abus_sack) seen++;
    end
  endtask

  initial begin
    int          cyc;
    logic        err;
    logic [31:0] rd;
    int          seen;

    abus_rst      = 1'b1;
    abus_swrite   = 1'b0;
    abus_sread    = 1'b0;
    abus_sabort   = 1'b0;
    abus_saddress = '0;
    abus_swdata   = '0;
    abus_sstrb    = '0;
    repeat (3) @(posedge abus_clk);
    @(negedge abus_clk);
    abus_rst = 1'b0;

    // Reset state
    chk("rst_sack", 32'(abus_sack), 32'd0);
    chk("rst_serror", 32'(abus_serror), 32'd0);
    chk("rst_srdata", abus_srdata, 32'd0);

    // 1: write then same-bank read with penalty
    do_txn(1'b0, 1'b1, 16'h100, 32'hDEADBEEF, 4'hF, cyc, err, rd);
    chk("s1_wr_cyc", 32'(cyc), 32'd3);
    chk("s1_wr_err", 32'(err), 32'd0);
    do_txn(1'b1, 1'b0, 16'h100, 32'h0, 4'h0, cyc, err, rd);
    chk("s1_rd_cyc", 32'(cyc), 32'd5);
    chk("s1_rd_err", 32'(err), 32'd0);
    chk("s1_rd_data", rd, 32'hDEADBEEF);

    // 2: byte-lane merge on 0x102 (bank 0, penalties throughout)
    do_txn(1'b0, 1'b1, 16'h102, 32'h11223344, 4'hF, cyc, err, rd);
    chk("s2_wr1_cyc", 32'(cyc), 32'd4);
    do_txn(1'b0, 1'b1, 16'h102, 32'hAABBCCDD, 4'h5, cyc, err, rd);
    chk("s2_wr2_cyc", 32'(cyc), 32'd4);
    do_txn(1'b1, 1'b0, 16'h102, 32'h0, 4'h0, cyc, err, rd);
    chk("s2_rd_cyc", 32'(cyc), 32'd5);
    chk("s2_rd_data", rd, 32'h11BB33DD);

    // 3: bank alternation, no penalty; srdata holds between reads
    do_txn(1'b0, 1'b1, 16'h101, 32'h01234567, 4'hF, cyc, err, rd);
    chk("s3_wr101_cyc", 32'(cyc), 32'd3);
    do_txn(1'b0, 1'b1, 16'h103, 32'h5A5A5A5A, 4'hF, cyc, err, rd);
    chk("s3_wr103_cyc", 32'(cyc), 32'd4);
    do_txn(1'b1, 1'b0, 16'h102, 32'h0, 4'h0, cyc, err, rd);
    chk("s3_rd102_cyc", 32'(cyc), 32'd4);
    chk("s3_rd102_data", rd, 32'h11BB33DD);
    do_txn(1'b1, 1'b0, 16'h101, 32'h0, 4'h0, cyc, err, rd);
    chk("s3_rd101_cyc", 32'(cyc), 32'd4);
    chk("s3_rd101_data", rd, 32'h01234567);
    repeat (2) @(negedge abus_clk);
    chk("s3_hold", abus_srdata, 32'h01234567);
    do_txn(1'b1, 1'b0, 16'h100, 32'h0, 4'h0, cyc, err, rd);
    chk("s3_rd100_cyc", 32'(cyc), 32'd4);
    chk("s3_rd100_data", rd, 32'hDEADBEEF);

    // 4: aborted write to 0x103 (last completed bank is 0)
    abus_swrite   = 1'b1;
    abus_saddress = 16'h103;
    abus_swdata   = 32'hFFFFFFFF;
    abus_sstrb    = 4'hF;
    @(posedge abus_clk);
    @(negedge abus_clk);
    abus_sabort = 1'b1;
    @(posedge abus_clk);
    @(negedge abus_clk);
    abus_sabort = 1'b0;
    abus_swrite = 1'b0;
    count_acks(6, seen);
    chk("s4_abort_noack", 32'(seen), 32'd0);
    do_txn(1'b1, 1'b0, 16'h103, 32'h0, 4'h0, cyc, err, rd);
    chk("s4_rd_cyc", 32'(cyc), 32'd4);
    chk("s4_rd_data", rd, 32'h5A5A5A5A);

    // 5: out-of-range read below and write above the window
    do_txn(1'b1, 1'b0, 16'h0FF, 32'h0, 4'h0, cyc, err, rd);
    chk("s5_rd_cyc", 32'(cyc), 32'd4);
    chk("s5_rd_err", 32'(err), 32'd1);
    chk("s5_rd_data", rd, 32'h0);
    do_txn(1'b0, 1'b1, 16'h200, 32'h77777777, 4'hF, cyc, err, rd);
    chk("s5_wr_cyc", 32'(cyc), 32'd3);
    chk("s5_wr_err", 32'(err), 32'd1);
    chk("s5_wr_data", rd, 32'h0);
    // last bank is still 1 after the errors: 0x103 pays the penalty
    do_txn(1'b1, 1'b0, 16'h103, 32'h0, 4'h0, cyc, err, rd);
    chk("s5_rd103_cyc", 32'(cyc), 32'd5);
    chk("s5_rd103_data", rd, 32'h5A5A5A5A);
    do_txn(1'b1, 1'b0, 16'h100, 32'h0, 4'h0, cyc, err, rd);
    chk("s5_rd100_cyc", 32'(cyc), 32'd4);
    chk("s5_rd100_data", rd, 32'hDEADBEEF);

    // 6a: read and write together is an error
    do_txn(1'b1, 1'b1, 16'h100, 32'h12345678, 4'hF, cyc, err, rd);
    chk("s6_both_err", 32'(err), 32'd1);
    chk("s6_both_data", rd, 32'h0);

    // 6b: reset in cycle 1 of a write to 0x102
    abus_swrite   = 1'b1;
    abus_saddress = 16'h102;
    abus_swdata   = 32'hCAFEF00D;
    abus_sstrb    = 4'hF;
    @(posedge abus_clk);
    @(negedge abus_clk);
    abus_rst = 1'b1;
    @(posedge abus_clk);
    @(negedge abus_clk);
    abus_rst    = 1'b0;
    abus_swrite = 1'b0;
    count_acks(6, seen);
    chk("s6_rst_noack", 32'(seen), 32'd0);
    // last bank would be 0, but reset cleared it: no penalty
    do_txn(1'b1, 1'b0, 16'h102, 32'h0, 4'h0, cyc, err, rd);
    chk("s6_rd_cyc", 32'(cyc), 32'd4);
    chk("s6_rd_data", rd, 32'h11BB33DD);

    // Zero-strobe write completes and changes nothing
    do_txn(1'b0, 1'b1, 16'h100, 32'h00000000, 4'h0, cyc, err, rd);
    chk("strb0_cyc", 32'(cyc), 32'd4);
    chk("strb0_err", 32'(err), 32'd0);
    do_txn(1'b1, 1'b0, 16'h100, 32'h0, 4'h0, cyc, err, rd);
    chk("strb0_rd_data", rd, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_banked.md
# sram_banked

Parametrised multi-bank SRAM slave for the abus arbiter. It is the successor to the single-array wait-state SRAM and adds:

- byte-lane write strobes;
- independent read and write wait-state counts;
- bank interleaving with a same-bank recovery penalty;
- out-of-range error responses;
- registered, never-tristated read data.

It sits behind the bus arbiter as one slave and is fully synthesizable, with no behavioural memory model.

## Interface

Parameters:
- START_ADDR, 0: first word address decoded by this slave.
- SIZE, 256: total words; must be a multiple of BANKS.
- ADDR_WIDTH, 16: width of the word address.
- DATA_WIDTH, 32: data width; must be a multiple of 8.
- BANKS, 2: number of interleaved banks; power of 2, at least 1.
- RD_WAIT, 2: base wait cycles for a read.
- WR_WAIT, 1: base wait cycles for a write.

Ports (one clock; reset is synchronous and active-high):
- abus_clk, in, 1: clock; all logic on the rising edge.
- abus_rst, in, 1: synchronous, active-high reset.
- abus_swrite, in, 1: write request; held by the master until ack.
- abus_sread, in, 1: read request; held by the master until ack.
- abus_sabort, in, 1: cancels the pending transaction.
- abus_saddress, in, ADDR_WIDTH: word address.
- abus_swdata, in, DATA_WIDTH: write data.
- abus_sstrb, in, DATA_WIDTH/8: byte enables; bit i enables bits 8i+7:8i.
- abus_sack, out, 1: one-cycle completion pulse.
- abus_serror, out, 1: error qualifier; valid only while abus_sack is high.
- abus_srdata, out, DATA_WIDTH: read data, registered; holds its value between reads.

## Operation

- Address decode:
  - idx = abus_saddress - START_ADDR.
  - in_range = START_ADDR <= abus_saddress < START_ADDR+SIZE.
  - bank = idx mod BANKS; row = idx / BANKS.
- FSM states:
  - IDLE, on a request:
    - If read and write are both high, or the address is out of range: go to WAIT with the error flag set.
    - Otherwise: go to WAIT and load cnt = (read ? RD_WAIT : WR_WAIT) + penalty.
    - penalty = 1 when last_valid is set and bank == last_bank; otherwise 0.
  - WAIT:
    - If abus_sabort is high: go to IDLE; no access, no ack, last_bank unchanged.
    - Else if cnt != 0: cnt <= cnt-1.
    - Else (cnt == 0): perform the access and go to ACK.
  - ACK: abus_sack = 1 for exactly this cycle, then go to IDLE unconditionally. abus_sabort in ACK is ignored, because the access is already committed.
- Access performed on the WAIT→ACK edge:
  - Write: update only the strobed bytes of mem[bank][row].
  - Read: abus_srdata <= mem[bank][row].
  - Both: last_bank <= bank and last_valid <= 1.
- Error transactions:
  - Use the base wait count with no penalty.
  - No memory update.
  - abus_srdata <= 0 and abus_serror = 1 in ACK.
  - last_bank and last_valid are unchanged.
- abus_sabort in IDLE is ignored.
- A write with abus_sstrb == 0 completes normally and changes no bytes.
- Reset values:
  - state = IDLE, cnt = 0, last_valid = 0.
  - abus_sack = 0, abus_serror = 0, abus_srdata = 0.
  - Memory contents are not reset.

## Timing

- Cycle 0 is the first cycle a request is high in IDLE.
- WAIT occupies cycles 1 to N+1, where N = base wait + penalty.
- abus_sack is high in cycle N+2.
- abus_srdata is valid from cycle N+2 and holds until the next read or error completes.
- The master must deassert its request in cycle N+3; a request still high in cycle N+3 starts a new transaction.
- Reset asserted in any state returns the block to IDLE on the next edge:
  - no ack is produced and no write is committed;
  - the first transaction after reset carries no penalty.

## Structure

- Include file sram_banked_encoding.vh holds:
  - state localparams (IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2);
  - the counter width: $clog2(max(RD_WAIT, WR_WAIT) + 2).
- Sub-module sram_banked_fsm holds:
  - state register, cnt, the error flag, last_bank and last_valid;
  - outputs: access_en, ack and err.
- The top level holds the BANKS register arrays (generate loop), address decode, byte-merge logic and the srdata register.

## Test plan

Configuration for all scenarios: START_ADDR=0x100, SIZE=256, DATA_WIDTH=32, BANKS=2, RD_WAIT=2, WR_WAIT=1.

1. Write 0xDEADBEEF to 0x100 with strb 0xF -> ack in cycle 3, serror=0. Then read 0x100 (same bank, penalty) -> ack in cycle 5, srdata=0xDEADBEEF.
2. Write 0x11223344 to 0x102 with strb 0xF, then 0xAABBCCDD to 0x102 with strb 0x5, then read 0x102 -> srdata=0x11BB33DD.
3. Read 0x101 (bank 1) then 0x102 (bank 0) -> no penalty, each ack in cycle 4; srdata holds between the two acks.
4. Write to 0x103 with abus_sabort pulsed in cycle 1 -> no ack. A following read of 0x103 returns its prior contents, with no penalty when the previous completed bank differs.
5. Read 0x0FF, then write 0x200 -> read acks in cycle 4 and write acks in cycle 3, both with serror=1 and srdata=0; memory is unchanged.
6. Read and write requested together -> serror=1. Separately, abus_rst asserted in cycle 1 of a write -> sack stays 0, the target word is unchanged, and the next request acks with no penalty.
